// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and constants for the multi-port FPGA register file.
//   rf_clr_state_e  - clear-sequencer states
//   RfAddrWidthMax  - width of every register address port slice
//   rf_addr_valid() - true when an address names a writable/readable register
package ibex_pkg;

  typedef enum logic {
    RfClrClear,
    RfClrReady
  } rf_clr_state_e;

  localparam int unsigned RfAddrWidthMax = 5;

  // x0 is hard-wired to zero; with RV32E the upper 16 addresses do not exist.
  function automatic logic rf_addr_valid(input logic [RfAddrWidthMax-1:0] addr,
                                         input logic                      rv32e);
    return (addr != '0) && !(rv32e && addr[RfAddrWidthMax-1]);
  endfunction

endpackage

// File: rtl/ibex_register_file_fpga_bank.sv
// ibex_register_file_fpga_bank: one 1W/1R storage bank.
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address (asynchronous read)
//   rdata_o - read data
// Written as a plain array with a synchronous write and a combinational
// read so that FPGA tools map it onto distributed LUTRAM.
module ibex_register_file_fpga_bank #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned NumWords = 2 ** AddrWidth;

  // NOTE: the array deliberately has no reset; a reset port would stop the
  // tools from inferring LUTRAM. The clear sequencer in the top zeroes it.
  logic [DataWidth-1:0] mem_q [NumWords];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ibex_register_file_fpga_mp.sv
// ibex_register_file_fpga_mp: multi-port FPGA register file.
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset
//   clear_i - starts a clear sequence when the file is ready
//   raddr_i - NumReadPorts packed 5-bit read addresses
//   rdata_o - NumReadPorts packed read data words (combinational)
//   waddr_i - NumWritePorts packed 5-bit write addresses
//   wdata_i - NumWritePorts packed write data words
//   we_i    - per-port write enables
//   ready_o - high when the file is usable
// Storage is a grid of 1W/1R banks, one per (write port, read port) pair.
// A live-value table remembers which write port last wrote each register,
// and every read port picks its bank column through it.
module ibex_register_file_fpga_mp
  import ibex_pkg::*;
#(
  parameter bit          RV32E         = 1'b0,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumReadPorts  = 2,
  parameter int unsigned NumWritePorts = 1,
  parameter bit          WriteBypass   = 1'b0,
  parameter bit          ClearOnReset  = 1'b1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    clear_i,
  input  logic [NumReadPorts*RfAddrWidthMax-1:0]  raddr_i,
  output logic [NumReadPorts*DataWidth-1:0]       rdata_o,
  input  logic [NumWritePorts*RfAddrWidthMax-1:0] waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0]      wdata_i,
  input  logic [NumWritePorts-1:0]                we_i,
  output logic                                    ready_o
);

  localparam int unsigned AddrWidth = RV32E ? 4 : 5;
  localparam int unsigned NumWords  = 2 ** AddrWidth;
  localparam rf_clr_state_e StateAfterReset = ClearOnReset ? RfClrClear : RfClrReady;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  rf_clr_state_e        state_q;
  logic [AddrWidth-1:0] clr_cnt_q;
  logic                 ready;
  logic                 clearing;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StateAfterReset;
      clr_cnt_q <= AddrWidth'(1);
    end else begin
      unique case (state_q)
        RfClrClear: begin
          // x0 is never stored, so the walk covers 1..NumWords-1 only.
          if (clr_cnt_q == {AddrWidth{1'b1}}) begin
            state_q <= RfClrReady;
          end
          clr_cnt_q <= clr_cnt_q + AddrWidth'(1);
        end
        RfClrReady: begin
          if (clear_i) begin
            state_q   <= RfClrClear;
            clr_cnt_q <= AddrWidth'(1);
          end
        end
        default: state_q <= StateAfterReset;
      endcase
    end
  end

  assign ready    = (state_q == RfClrReady);
  assign clearing = (state_q == RfClrClear);
  assign ready_o  = ready;

  // ---------------------------------------------------------------------------
  // Write ports
  // ---------------------------------------------------------------------------
  logic [RfAddrWidthMax-1:0] waddr_full [NumWritePorts];
  logic [AddrWidth-1:0]      waddr_bank [NumWritePorts];
  logic [DataWidth-1:0]      wdata      [NumWritePorts];
  logic [NumWritePorts-1:0]  wr_acc;

  logic [NumWritePorts-1:0]  bank_we;
  logic [AddrWidth-1:0]      bank_waddr [NumWritePorts];
  logic [DataWidth-1:0]      bank_wdata [NumWritePorts];

  for (genvar w = 0; w < NumWritePorts; w++) begin : g_wport
    assign waddr_full[w] = waddr_i[w*RfAddrWidthMax +: RfAddrWidthMax];
    assign waddr_bank[w] = waddr_full[w][AddrWidth-1:0];
    assign wdata[w]      = wdata_i[w*DataWidth +: DataWidth];
    // Writes are dropped while clearing and for x0 / nonexistent registers.
    assign wr_acc[w]     = we_i[w] & ready & rf_addr_valid(waddr_full[w], RV32E);

    if (w == 0) begin : g_clr_col
      // Column 0 doubles as the clear target: the LVT is forced to 0 for the
      // same address, so zeroing this column zeroes the architectural value.
      assign bank_we[w]    = wr_acc[w] | clearing;
      assign bank_waddr[w] = clearing ? clr_cnt_q : waddr_bank[w];
      assign bank_wdata[w] = clearing ? '0 : wdata[w];
    end else begin : g_plain_col
      assign bank_we[w]    = wr_acc[w];
      assign bank_waddr[w] = waddr_bank[w];
      assign bank_wdata[w] = wdata[w];
    end
  end

  // ---------------------------------------------------------------------------
  // Bank grid
  // ---------------------------------------------------------------------------
  logic [RfAddrWidthMax-1:0] raddr_full [NumReadPorts];
  logic [AddrWidth-1:0]      raddr_bank [NumReadPorts];
  logic [DataWidth-1:0]      bank_rdata [NumWritePorts][NumReadPorts];
  logic [DataWidth-1:0]      stored     [NumReadPorts];

  for (genvar r = 0; r < NumReadPorts; r++) begin : g_raddr
    assign raddr_full[r] = raddr_i[r*RfAddrWidthMax +: RfAddrWidthMax];
    assign raddr_bank[r] = raddr_full[r][AddrWidth-1:0];
  end

  for (genvar w = 0; w < NumWritePorts; w++) begin : g_bank_w
    for (genvar r = 0; r < NumReadPorts; r++) begin : g_bank_r
      ibex_register_file_fpga_bank #(
        .AddrWidth(AddrWidth),
        .DataWidth(DataWidth)
      ) u_bank (
        .clk_i  (clk_i),
        .we_i   (bank_we[w]),
        .waddr_i(bank_waddr[w]),
        .wdata_i(bank_wdata[w]),
        .raddr_i(raddr_bank[r]),
        .rdata_o(bank_rdata[w][r])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Live-value table
  // ---------------------------------------------------------------------------
  if (NumWritePorts > 1) begin : g_lvt
    logic lvt_q [NumWords];

    // NOTE: unlike the banks, the LVT is a small flop array and is reset, so
    // reads steer to column 0 (the cleared column) straight out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < NumWords; i++) begin
          lvt_q[i] <= 1'b0;
        end
      end else begin
        if (clearing) begin
          lvt_q[clr_cnt_q] <= 1'b0;
        end
        // Ascending port order: on a same-address conflict port 1 wins.
        for (int w = 0; w < NumWritePorts; w++) begin
          if (wr_acc[w]) begin
            lvt_q[waddr_bank[w]] <= 1'(w);
          end
        end
      end
    end

    for (genvar r = 0; r < NumReadPorts; r++) begin : g_sel
      assign stored[r] = bank_rdata[lvt_q[raddr_bank[r]]][r];
    end
  end else begin : g_no_lvt
    for (genvar r = 0; r < NumReadPorts; r++) begin : g_sel
      assign stored[r] = bank_rdata[0][r];
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: bypass and zero gating
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < NumReadPorts; r++) begin : g_rport
    logic [DataWidth-1:0] rd_data;

    // NOTE: rd_data is assigned first unconditionally so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
      rd_data = stored[r];
      if (WriteBypass) begin
        // Later ports override earlier ones: the highest matching port wins.
        for (int w = 0; w < NumWritePorts; w++) begin
          if (wr_acc[w] && (waddr_full[w] == raddr_full[r])) begin
            rd_data = wdata[w];
          end
        end
      end
      if (!ready || !rf_addr_valid(raddr_full[r], RV32E)) begin
        rd_data = '0;
      end
    end

    assign rdata_o[r*DataWidth +: DataWidth] = rd_data;
  end

endmodule

// File: tb/tb_ibex_register_file_fpga_mp.sv
module tb_ibex_register_file_fpga_mp;

  // Four DUT configurations share one stimulus stream:
  //   0: RV32I 2W/4R no bypass   1: RV32I 2W/4R bypass
  //   2: RV32E 2W/4R no bypass   3: RV32I 1W/1R no clear on reset
  localparam int NCFG = 4;

  function automatic bit cfg_e(input int c);   return c == 2;             endfunction
  function automatic bit cfg_byp(input int c); return c == 1;             endfunction
  function automatic int cfg_nw(input int c);  return (c == 3) ? 1 : 2;   endfunction
  function automatic int cfg_nr(input int c);  return (c == 3) ? 1 : 4;   endfunction
  function automatic bit cfg_cor(input int c); return c != 3;             endfunction
  function automatic int cfg_words(input int c); return cfg_e(c) ? 16 : 32; endfunction

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic [19:0]  raddr;
  logic [9:0]   waddr;
  logic [63:0]  wdata;
  logic [1:0]   we;
  logic [127:0] rdata_a, rdata_b, rdata_e;
  logic [31:0]  rdata_d;
  logic         ready_a, ready_b, ready_e, ready_d;

  always #5 clk = ~clk;

  ibex_register_file_fpga_mp #(.RV32E(1'b0), .DataWidth(32), .NumReadPorts(4), .NumWritePorts(2),
    .WriteBypass(1'b0), .ClearOnReset(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .raddr_i(raddr), .rdata_o(rdata_a),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .ready_o(ready_a));

  ibex_register_file_fpga_mp #(.RV32E(1'b0), .DataWidth(32), .NumReadPorts(4), .NumWritePorts(2),
    .WriteBypass(1'b1), .ClearOnReset(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .raddr_i(raddr), .rdata_o(rdata_b),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .ready_o(ready_b));

  ibex_register_file_fpga_mp #(.RV32E(1'b1), .DataWidth(32), .NumReadPorts(4), .NumWritePorts(2),
    .WriteBypass(1'b0), .ClearOnReset(1'b1)) dut_e (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .raddr_i(raddr), .rdata_o(rdata_e),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .ready_o(ready_e));

  ibex_register_file_fpga_mp #(.RV32E(1'b0), .DataWidth(32), .NumReadPorts(1), .NumWritePorts(1),
    .WriteBypass(1'b0), .ClearOnReset(1'b0)) dut_d (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .raddr_i(raddr[4:0]), .rdata_o(rdata_d),
    .waddr_i(waddr[4:0]), .wdata_i(wdata[31:0]), .we_i(we[0]), .ready_o(ready_d));

  // ---------------------------------------------------------------------------
  // Reference model: architectural register values per configuration, plus
  // the number of clear cycles still to run (0 means usable).
  // ---------------------------------------------------------------------------
  logic [31:0] m_regs  [NCFG][32];
  bit          m_known [NCFG][32];
  int          m_clr   [NCFG];
  int          fr      [NCFG];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_rd(input int c, input int p);
    case (c)
      0:       return rdata_a[p*32 +: 32];
      1:       return rdata_b[p*32 +: 32];
      2:       return rdata_e[p*32 +: 32];
      default: return rdata_d;
    endcase
  endfunction

  function automatic logic dut_ready(input int c);
    case (c)
      0:       return ready_a;
      1:       return ready_b;
      2:       return ready_e;
      default: return ready_d;
    endcase
  endfunction

  function automatic bit addr_ok(input int c, input logic [4:0] a);
    return (a != 5'd0) && !(cfg_e(c) && a[4]);
  endfunction

  task automatic m_read(input int c, input logic [4:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v     = '0;
    if (m_clr[c] > 0) return;
    if (!addr_ok(c, a)) return;
    v     = m_regs[c][a];
    known = m_known[c][a];
    if (cfg_byp(c) && !rst) begin
      for (int w = 0; w < cfg_nw(c); w++) begin
        if (we[w] && (waddr[w*5 +: 5] == a)) begin
          v     = wdata[w*32 +: 32];
          known = 1'b1;
        end
      end
    end
  endtask

  task automatic m_zero_all(input int c);
    for (int i = 0; i < 32; i++) begin
      m_regs[c][i]  = '0;
      m_known[c][i] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      if (cfg_cor(c)) begin
        m_clr[c] = cfg_words(c) - 1;
        m_zero_all(c);
      end else begin
        // An interrupted clear leaves a partly-zeroed file: forget it all.
        if (m_clr[c] > 0) begin
          for (int i = 0; i < 32; i++) m_known[c][i] = 1'b0;
        end
        m_clr[c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    logic [4:0] a;
    if (rst) return;
    for (int c = 0; c < NCFG; c++) begin
      if (m_clr[c] > 0) begin
        m_clr[c]--;
      end else begin
        for (int w = 0; w < cfg_nw(c); w++) begin
          a = waddr[w*5 +: 5];
          if (we[w] && addr_ok(c, a)) begin
            m_regs[c][a]  = wdata[w*32 +: 32];
            m_known[c][a] = 1'b1;
          end
        end
        // Reads are forced to zero for the whole clear, so the file can be
        // treated as all-zero from the moment the clear starts.
        if (clear) begin
          m_clr[c] = cfg_words(c) - 1;
          m_zero_all(c);
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] v;
    bit          k;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("ready_c%0d", c), {31'b0, dut_ready(c)}, {31'b0, m_clr[c] == 0});
      for (int p = 0; p < cfg_nr(c); p++) begin
        m_read(c, raddr[p*5 +: 5], v, k);
        if (k) check($sformatf("rd_c%0d_p%0d_a%0d", c, p, raddr[p*5 +: 5]), dut_rd(c, p), v);
      end
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #2;
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] we_v, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1, input logic [19:0] ra,
                       input logic clr);
    we    = we_v;
    waddr = {wa1, wa0};
    wdata = {wd1, wd0};
    raddr = ra;
    clear = clr;
  endtask

  task automatic do_reset(input int cycles);
    rst   = 1'b1;
    we    = '0;
    clear = 1'b0;
    model_reset();
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic rec_ready(input int k);
    #1;
    for (int c = 0; c < NCFG; c++) begin
      if (fr[c] < 0 && dut_ready(c)) fr[c] = k;
    end
  endtask

  task automatic fr_clear();
    for (int c = 0; c < NCFG; c++) fr[c] = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors for configuration 0 (all ports) and 1 (port 0)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]   we;
    logic [4:0]   wa0;
    logic [31:0]  wd0;
    logic [4:0]   wa1;
    logic [31:0]  wd1;
    logic [19:0]  ra;     // {p3, p2, p1, p0}
    logic [127:0] exp_a;  // {p3, p2, p1, p0}
    logic [31:0]  exp_b0;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [1:0] we_v, input logic [4:0] wa0, input logic [31:0] wd0,
                                  input logic [4:0] wa1, input logic [31:0] wd1, input logic [19:0] ra,
                                  input logic [127:0] ea, input logic [31:0] eb0);
    vec_t v;
    v.we = we_v; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra = ra; v.exp_a = ea; v.exp_b0 = eb0;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [4:0]  wa0, wa1;
    logic [19:0] ra;
    for (int c = 0; c < NCFG; c++) begin
      m_clr[c] = 0;
      for (int i = 0; i < 32; i++) begin
        m_regs[c][i]  = '0;
        m_known[c][i] = 1'b0;
      end
    end
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 20'd0, 1'b0);

    // Reset and the clear that follows it.
    do_reset(3);
    fr_clear();
    for (int k = 0; k < 40; k++) begin
      rec_ready(k);
      step();
    end
    check("rst_clr_len_a", 32'(fr[0]), 32'd31);
    check("rst_clr_len_e", 32'(fr[2]), 32'd15);
    check("rst_ready_d",   32'(fr[3]), 32'd0);

    // Every register reads zero after the clear.
    for (int a = 0; a < 32; a++) begin
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {4{5'(a)}}, 1'b0);
      step();
    end

    // Directed table.
    add_vec(2'b11, 5'd5, 32'h1111_1111, 5'd7, 32'h2222_2222, {5'd5, 5'd0, 5'd7, 5'd5},
            128'd0, 32'h1111_1111);
    add_vec(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {5'd5, 5'd0, 5'd7, 5'd5},
            {32'h1111_1111, 32'd0, 32'h2222_2222, 32'h1111_1111}, 32'h1111_1111);
    add_vec(2'b11, 5'd9, 32'hAAAA_AAAA, 5'd9, 32'h5555_5555, {5'd7, 5'd5, 5'd9, 5'd9},
            {32'h2222_2222, 32'h1111_1111, 32'd0, 32'd0}, 32'h5555_5555);
    add_vec(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {5'd0, 5'd9, 5'd9, 5'd9},
            {32'd0, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555}, 32'h5555_5555);
    add_vec(2'b01, 5'd9, 32'h0BAD_F00D, 5'd0, 32'd0, {5'd0, 5'd9, 5'd9, 5'd9},
            {32'd0, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555}, 32'h0BAD_F00D);
    add_vec(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {5'd0, 5'd9, 5'd9, 5'd9},
            {32'd0, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D}, 32'h0BAD_F00D);
    add_vec(2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'd0, {4{5'd3}},
            128'd0, 32'hDEAD_BEEF);
    add_vec(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {4{5'd3}},
            {4{32'hDEAD_BEEF}}, 32'hDEAD_BEEF);
    add_vec(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, {4{5'd0}},
            128'd0, 32'd0);
    add_vec(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {4{5'd0}},
            128'd0, 32'd0);
    add_vec(2'b11, 5'd31, 32'h1234_5678, 5'd2, 32'h0000_0002, {5'd7, 5'd5, 5'd2, 5'd31},
            {32'h2222_2222, 32'h1111_1111, 32'd0, 32'd0}, 32'h1234_5678);
    add_vec(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {5'd7, 5'd5, 5'd2, 5'd31},
            {32'h2222_2222, 32'h1111_1111, 32'h0000_0002, 32'h1234_5678}, 32'h1234_5678);
    add_vec(2'b01, 5'd20, 32'h0000_0020, 5'd0, 32'd0, {5'd0, 5'd0, 5'd20, 5'd20},
            128'd0, 32'h0000_0020);
    add_vec(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {5'd0, 5'd0, 5'd20, 5'd20},
            {32'd0, 32'd0, 32'h0000_0020, 32'h0000_0020}, 32'h0000_0020);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1, vecs[i].ra, 1'b0);
      #1;
      for (int p = 0; p < 4; p++) begin
        check($sformatf("vec%0d_a_p%0d", i, p), dut_rd(0, p), vecs[i].exp_a[p*32 +: 32]);
      end
      check($sformatf("vec%0d_b_p0", i), dut_rd(1, 0), vecs[i].exp_b0);
      step();
    end
    // RV32E: address 20 does not exist, the write above was dropped.
    check("e_rd20_dropped", dut_rd(2, 0), 32'd0);

    // clear_i together with a write, writes lost during the clear, and a
    // second clear_i pulse that must not restart the sequence.
    drive(2'b01, 5'd31, 32'h7777_7777, 5'd0, 32'd0, {4{5'd31}}, 1'b1);
    step();
    fr_clear();
    for (int k = 0; k < 45; k++) begin
      drive((k < 31) ? 2'b01 : 2'b00, 5'd31, $urandom, 5'd0, 32'd0, {4{5'd31}}, k == 10);
      rec_ready(k);
      step();
    end
    check("clr_len_a", 32'(fr[0]), 32'd31);
    check("clr_len_b", 32'(fr[1]), 32'd31);
    check("clr_len_e", 32'(fr[2]), 32'd15);
    check("clr_len_d", 32'(fr[3]), 32'd31);
    check("x31_after_clear", dut_rd(0, 0), 32'd0);

    // A write in the first ready cycle is accepted.
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {4{5'd4}}, 1'b1);
    step();
    for (int k = 0; k < 36; k++) begin
      drive((k <= 31) ? 2'b01 : 2'b00, 5'd4, (k == 31) ? 32'h4444_4444 : $urandom,
            5'd0, 32'd0, {4{5'd4}}, 1'b0);
      step();
    end
    check("first_ready_write_a", dut_rd(0, 0), 32'h4444_4444);
    check("first_ready_write_e", dut_rd(2, 0), 32'h4444_4444);

    // Reset in the middle of a clear restarts it from the beginning.
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {4{5'd4}}, 1'b1);
    step();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, {4{5'd4}}, 1'b0);
    repeat (5) step();
    do_reset(2);
    fr_clear();
    for (int k = 0; k < 40; k++) begin
      rec_ready(k);
      step();
    end
    check("midclr_rst_len_a", 32'(fr[0]), 32'd31);
    check("midclr_rst_len_e", 32'(fr[2]), 32'd15);
    check("midclr_rst_ready_d", 32'(fr[3]), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wa0 = 5'($urandom_range(0, 31));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      for (int p = 0; p < 4; p++) begin
        case ($urandom_range(0, 3))
          0:       ra[p*5 +: 5] = wa0;
          1:       ra[p*5 +: 5] = wa1;
          default: ra[p*5 +: 5] = 5'($urandom_range(0, 31));
        endcase
      end
      drive(2'($urandom_range(0, 3)), wa0, $urandom, wa1, $urandom, ra,
            $urandom_range(0, 79) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_register_file_fpga_mp.md
# ibex_register_file_fpga_mp

Multi-port, FPGA-oriented general-purpose register file for Ibex. It provides a parametrised number of asynchronous read ports and one or two synchronous write ports, built from LUTRAM-friendly 1W/1R banks combined by a live-value table (LVT). A clear sequencer zeroes every register after reset or on request, because LUTRAM contents have no reset. It sits in the ID/WB stages in place of the single-write FPGA register file when dual-issue or extra read ports are needed.

## Interface
- RV32E, 0: 1 gives 16 registers (ADDR_WIDTH 4); 0 gives 32 registers (ADDR_WIDTH 5).
- DataWidth, 32: register width in bits.
- NumReadPorts, 2: number of read ports, 1..4.
- NumWritePorts, 1: number of write ports, 1..2.
- WriteBypass, 0: 1 makes a same-cycle write visible on a matching read.
- ClearOnReset, 1: 1 starts a clear sequence on reset.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  pulse in READY starts a clear sequence.
- raddr_i  in  NumReadPorts*5  read addresses; port p uses bits [5p+4:5p].
- rdata_o  out  NumReadPorts*DataWidth  read data, combinational from raddr_i.
- waddr_i  in  NumWritePorts*5  write addresses.
- wdata_i  in  NumWritePorts*DataWidth  write data.
- we_i  in  NumWritePorts  write enables.
- ready_o  out  1  high when the file is usable (state READY).

## Operation
- Storage is NumWritePorts × NumReadPorts banks. Bank (w,r) is written only by write port w and read only by read port r.
- LVT: one NUM_WORDS-entry flop array of write-port indices, asynchronously reset to 0. It is updated on every accepted write. Read port r returns bank (LVT[addr], r). When NumWritePorts=1 the LVT is omitted.
- Address 0 always reads '0, and writes to address 0 are dropped.
- With RV32E=1, addresses with bit 4 set read '0 and writes to them are dropped.
- Write conflict: if both ports write the same nonzero address in the same cycle, port 1 wins. Both banks are written, and the LVT records 1.
- Bypass (WriteBypass=1): if a read address matches a nonzero address being written this cycle, rdata returns that wdata; on a double match the highest port wins. With WriteBypass=0, the read returns the old value.
- FSM states are CLEAR and READY.
  - Reset puts the FSM in CLEAR with counter=1 when ClearOnReset=1, or in READY otherwise.
  - In CLEAR, each cycle writes '0 to address counter in bank column 0, sets LVT[counter]=0, and increments counter.
  - After writing NUM_WORDS-1 the FSM goes to READY.
  - clear_i in READY goes to CLEAR with counter=1. clear_i in CLEAR is ignored (no restart).
- In CLEAR, we_i is ignored (writes are lost, not queued), and all rdata_o are forced to '0.
- ready_o = (state==READY).

## Timing
- Reads: zero-cycle combinational latency from raddr_i, and from waddr_i/wdata_i/we_i when bypass is on.
- Writes: data is visible on reads in the cycle after the write edge.
- During rst_i high:
  - ready_o=0 if ClearOnReset=1, else 1.
  - rdata_o='0 when ClearOnReset=1.
  - Memory contents are undefined until cleared.
- Clear length is NUM_WORDS-1 cycles: 31 for RV32I, 15 for RV32E.
  - ready_o rises on the edge after the last clear write.
  - A write presented in that first READY cycle is accepted.
- Reset asserted mid-clear: the sequence restarts from counter=1 when reset releases (ClearOnReset=1). With ClearOnReset=0, the FSM goes to READY and contents are left as they were.
- clear_i in the same cycle as we_i in READY: the write is accepted, and clearing begins on the next edge. The written register is then zeroed when the counter reaches it.

## Structure
- Package ibex_pkg holds:
  - typedef rf_clr_state_e {RfClrClear, RfClrReady};
  - constant RfAddrWidthMax=5.
- Sub-module ibex_register_file_fpga_bank: one NUM_WORDS×DataWidth array with synchronous write, asynchronous read and no reset, so RAM32M/RAM64M primitives are inferred. The top instantiates it in a generate loop over (w,r).
- The top contains the LVT, bypass muxes, clear FSM/counter and address gating.

## Test plan
- Reset with ClearOnReset=1, RV32I, then release: ready_o low for exactly 31 cycles, then high; every register reads 0x0000_0000.
- Dual write: port 0 writes x5=0x1111_1111 and port 1 writes x7=0x2222_2222 in one cycle. Next cycle, read ports 0..3 read x5/x7/x0/x5 and return 0x1111_1111/0x2222_2222/0/0x1111_1111.
- Conflict: both ports write x9 (0xAAAA_AAAA on port 0, 0x5555_5555 on port 1). The read returns 0x5555_5555, and the LVT entry for x9 is 1.
- Bypass: WriteBypass=1, write x3=0xDEAD_BEEF while reading x3 in the same cycle returns 0xDEAD_BEEF. With WriteBypass=0 it returns the prior value 0x0.
- clear_i after writing x31=0x1234_5678: ready_o falls for 31 cycles, we_i=1 to x31 during the clear is lost, and x31 reads 0 afterwards. A second clear_i pulse mid-clear does not extend the 31 cycles.
- RV32E=1: write to address 20 is dropped and reading address 20 returns 0. The clear takes 15 cycles. Writing x0=0xFFFF_FFFF leaves x0 reading 0.
